// File: rtl/fpu_exec_ctrl_if.sv
// Bundles the decode-issue, FPU-operand, hazard and writeback signals of the FPU execute sequencer.
// The master side drives the issue and result inputs; the slave side is the sequencer.
interface fpu_exec_ctrl_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned LAT_W = 4
);
  logic             issue_valid;
  logic [4:0]       issue_cont;
  logic [LAT_W-1:0] issue_lat;
  logic [DW-1:0]    issue_x1;
  logic [DW-1:0]    issue_x2;
  logic [4:0]       issue_rd;
  logic             issue_rd_f;
  logic             flush;
  logic [DW-1:0]    fpu_x1;
  logic [DW-1:0]    fpu_x2;
  logic [4:0]       fpu_cont;
  logic [DW-1:0]    fpu_y;
  logic             stall_req;
  logic             busy;
  logic [4:0]       pend_rd;
  logic             pend_rd_f;
  logic             wb_valid;
  logic [DW-1:0]    wb_data;
  logic [4:0]       wb_rd;
  logic             wb_rd_f;

  modport master (
    output issue_valid, issue_cont, issue_lat, issue_x1, issue_x2, issue_rd, issue_rd_f,
    output flush, fpu_y,
    input  fpu_x1, fpu_x2, fpu_cont, stall_req, busy, pend_rd, pend_rd_f,
    input  wb_valid, wb_data, wb_rd, wb_rd_f
  );

  modport slave (
    input  issue_valid, issue_cont, issue_lat, issue_x1, issue_x2, issue_rd, issue_rd_f,
    input  flush, fpu_y,
    output fpu_x1, fpu_x2, fpu_cont, stall_req, busy, pend_rd, pend_rd_f,
    output wb_valid, wb_data, wb_rd, wb_rd_f
  );
endinterface

// File: rtl/fpu_exec_ctrl.sv
// Execute-stage sequencer for the multi-cycle FPU: holds operands for the op latency,
// stalls the pipeline meanwhile, and emits one writeback beat with the sampled result.
module fpu_exec_ctrl #(
  parameter int unsigned DW    = 32,
  parameter int unsigned LAT_W = 4
) (
  input logic           clk,
  input logic           rst,
  fpu_exec_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state_q;
  logic [LAT_W-1:0] cnt_q;
  logic [DW-1:0]    x1_q;
  logic [DW-1:0]    x2_q;
  logic [4:0]       cont_q;
  logic [4:0]       pend_rd_q;
  logic             pend_rd_f_q;
  logic             wb_valid_q;
  logic [DW-1:0]    wb_data_q;
  logic [4:0]       wb_rd_q;
  logic             wb_rd_f_q;
  logic             issue_fire;

  assign issue_fire = (state_q == S_IDLE) && bus.issue_valid && !bus.flush;

  // Issue cycle stalls combinationally; the WAIT state holds the stall until the sample edge.
  assign bus.stall_req = issue_fire || (state_q == S_WAIT);
  assign bus.busy      = (state_q == S_WAIT);
  assign bus.fpu_x1    = x1_q;
  assign bus.fpu_x2    = x2_q;
  assign bus.fpu_cont  = cont_q;
  assign bus.pend_rd   = pend_rd_q;
  assign bus.pend_rd_f = pend_rd_f_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_rd_f   = wb_rd_f_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      cont_q      <= '0;
      pend_rd_q   <= '0;
      pend_rd_f_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_rd_f_q   <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        // Operand registers keep their last value while idle so the FPU inputs stay quiet.
        if (issue_fire) begin
          x1_q        <= bus.issue_x1;
          x2_q        <= bus.issue_x2;
          cont_q      <= bus.issue_cont;
          pend_rd_q   <= bus.issue_rd;
          pend_rd_f_q <= bus.issue_rd_f;
          cnt_q       <= bus.issue_lat;
          state_q     <= S_WAIT;
        end
      end else begin
        // Flush wins over a counter expiring in the same cycle.
        if (bus.flush) begin
          cnt_q       <= '0;
          pend_rd_q   <= '0;
          pend_rd_f_q <= 1'b0;
          state_q     <= S_IDLE;
        end else if (cnt_q == '0) begin
          wb_valid_q  <= 1'b1;
          wb_data_q   <= bus.fpu_y;
          wb_rd_q     <= pend_rd_q;
          wb_rd_f_q   <= pend_rd_f_q;
          pend_rd_q   <= '0;
          pend_rd_f_q <= 1'b0;
          state_q     <= S_IDLE;
        end else begin
          cnt_q <= cnt_q - LAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_exec_ctrl.sv
// Bench for fpu_exec_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a cycle-number based behavioural model.
module tb_fpu_exec_ctrl;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT_W = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  fpu_exec_ctrl_if #(.DW(DW), .LAT_W(LAT_W)) bus ();

  fpu_exec_ctrl #(.DW(DW), .LAT_W(LAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Model: an op accepted in cycle T is in flight for cycles T+1..T+1+N, wb beat at T+2+N.
  bit          m_busy;
  int          m_done;
  int          m_wb_cyc;
  logic [31:0] m_x1, m_x2, m_wb_data;
  logic [4:0]  m_cont, m_rd, m_wb_rd;
  logic        m_rd_f, m_wb_rd_f;

  task automatic model_reset();
    m_busy = 0; m_done = -1; m_wb_cyc = -1;
    m_x1 = '0; m_x2 = '0; m_cont = '0; m_rd = '0; m_rd_f = 1'b0;
    m_wb_data = '0; m_wb_rd = '0; m_wb_rd_f = 1'b0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    logic issue_ok;
    if (rst) model_reset();
    issue_ok = bus.issue_valid && !bus.flush;
    chk("m_busy",      bus.busy,      m_busy);
    chk("m_stall",     bus.stall_req, m_busy || issue_ok);
    chk("m_pend_rd",   bus.pend_rd,   m_busy ? m_rd : 5'd0);
    chk("m_pend_rd_f", bus.pend_rd_f, m_busy ? m_rd_f : 1'b0);
    chk("m_fpu_x1",    bus.fpu_x1,    m_x1);
    chk("m_fpu_x2",    bus.fpu_x2,    m_x2);
    chk("m_fpu_cont",  bus.fpu_cont,  m_cont);
    chk("m_wb_valid",  bus.wb_valid,  cyc == m_wb_cyc);
    chk("m_wb_data",   bus.wb_data,   m_wb_data);
    chk("m_wb_rd",     bus.wb_rd,     m_wb_rd);
    chk("m_wb_rd_f",   bus.wb_rd_f,   m_wb_rd_f);
    if (!rst) begin
      if (m_busy) begin
        if (bus.flush) m_busy = 0;
        else if (cyc == m_done) begin
          m_wb_cyc = cyc + 1; m_wb_data = bus.fpu_y; m_wb_rd = m_rd; m_wb_rd_f = m_rd_f;
          m_busy = 0;
        end
      end else if (issue_ok) begin
        m_busy = 1; m_done = cyc + 1 + int'(bus.issue_lat);
        m_x1 = bus.issue_x1; m_x2 = bus.issue_x2; m_cont = bus.issue_cont;
        m_rd = bus.issue_rd; m_rd_f = bus.issue_rd_f;
      end
    end
  end

  task automatic set_issue(input logic v, input logic [4:0] c, input logic [3:0] l,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] r, input logic rf);
    bus.issue_valid = v; bus.issue_cont = c; bus.issue_lat = l;
    bus.issue_x1 = a; bus.issue_x2 = b; bus.issue_rd = r; bus.issue_rd_f = rf;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; bus.flush = 1'b0; bus.fpu_y = '0;
    set_issue(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (3) next_cycle();
    rst = 1'b0;

    // Idle after reset
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_stall", bus.stall_req, 1'b0);
      chk("idle_wbv",   bus.wb_valid,  1'b0);
      chk("idle_wbd",   bus.wb_data,   32'd0);
      next_cycle();
    end

    // fadd, latency 4
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        set_issue(1'b1, 5'b10000, 4'd4, 32'h3F800000, 32'h40000000, 5'd5, 1'b1);
        bus.fpu_y = 32'h40400000;
      end
      if (k == 1) bus.issue_valid = 1'b0;
      @(negedge clk);
      chk("fadd_stall", bus.stall_req, k <= 5);
      chk("fadd_busy",  bus.busy, k >= 1 && k <= 5);
      chk("fadd_pend",  bus.pend_rd, (k >= 1 && k <= 5) ? 5 : 0);
      chk("fadd_wbv",   bus.wb_valid, k == 6);
      if (k == 1) chk("fadd_x1", bus.fpu_x1, 32'h3F800000);
      if (k == 6) begin
        chk("fadd_wbd",  bus.wb_data, 32'h40400000);
        chk("fadd_wbrd", bus.wb_rd,   5'd5);
        chk("fadd_wbf",  bus.wb_rd_f, 1'b1);
      end
      next_cycle();
    end

    // feq, latency 0
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        set_issue(1'b1, 5'b10111, 4'd0, 32'h40490FDB, 32'h40490FDB, 5'd7, 1'b0);
        bus.fpu_y = 32'h00000001;
      end
      if (k == 1) bus.issue_valid = 1'b0;
      @(negedge clk);
      chk("feq_stall", bus.stall_req, k <= 1);
      chk("feq_busy",  bus.busy, k == 1);
      chk("feq_wbv",   bus.wb_valid, k == 2);
      if (k == 2) begin
        chk("feq_wbd",  bus.wb_data, 32'h00000001);
        chk("feq_wbrd", bus.wb_rd,   5'd7);
        chk("feq_wbf",  bus.wb_rd_f, 1'b0);
      end
      next_cycle();
    end

    // fdiv flushed in cycle 3, fresh fadd at cycle 5
    for (int k = 0; k < 13; k++) begin
      if (k == 0) begin
        set_issue(1'b1, 5'b00011, 4'd6, 32'h41200000, 32'h40000000, 5'd9, 1'b1);
        bus.fpu_y = 32'hDEAD0000;
      end
      if (k == 1) bus.issue_valid = 1'b0;
      if (k == 3) bus.flush = 1'b1;
      if (k == 4) bus.flush = 1'b0;
      if (k == 5) begin
        set_issue(1'b1, 5'b10000, 4'd4, 32'h3F800000, 32'h40000000, 5'd3, 1'b1);
        bus.fpu_y = 32'h40400000;
      end
      if (k == 6) bus.issue_valid = 1'b0;
      @(negedge clk);
      chk("fl_wbv",   bus.wb_valid, k == 11);
      chk("fl_busy",  bus.busy, (k >= 1 && k <= 3) || (k >= 6 && k <= 10));
      chk("fl_stall", bus.stall_req, k <= 3 || (k >= 5 && k <= 10));
      chk("fl_pend",  bus.pend_rd, (k >= 1 && k <= 3) ? 9 : ((k >= 6 && k <= 10) ? 3 : 0));
      if (k == 11) chk("fl_wbd", bus.wb_data, 32'h40400000);
      next_cycle();
    end

    // Back-to-back: second issue held while first is in flight
    for (int k = 0; k < 14; k++) begin
      if (k == 0) begin
        set_issue(1'b1, 5'b10010, 4'd4, 32'hAAAA0001, 32'hAAAA0002, 5'd10, 1'b1);
        bus.fpu_y = 32'h11111111;
      end
      if (k == 1) set_issue(1'b1, 5'b10001, 4'd4, 32'hBBBB0001, 32'hBBBB0002, 5'd11, 1'b0);
      if (k == 6) bus.fpu_y = 32'h22222222;
      if (k == 7) bus.issue_valid = 1'b0;
      @(negedge clk);
      chk("b2b_wbv",   bus.wb_valid, k == 6 || k == 12);
      chk("b2b_stall", bus.stall_req, k <= 11);
      chk("b2b_pend",  bus.pend_rd, (k >= 1 && k <= 5) ? 10 : ((k >= 7 && k <= 11) ? 11 : 0));
      if (k >= 1) chk("b2b_x1", bus.fpu_x1, (k <= 6) ? 32'hAAAA0001 : 32'hBBBB0001);
      if (k == 6) begin
        chk("b2b_wbd1", bus.wb_data, 32'h11111111);
        chk("b2b_wbr1", bus.wb_rd,   5'd10);
      end
      if (k == 12) begin
        chk("b2b_wbd2", bus.wb_data, 32'h22222222);
        chk("b2b_wbr2", bus.wb_rd,   5'd11);
        chk("b2b_wbf2", bus.wb_rd_f, 1'b0);
      end
      next_cycle();
    end

    // Latency 15 op killed by reset in cycle 8
    for (int k = 0; k < 21; k++) begin
      if (k == 0) begin
        set_issue(1'b1, 5'b00011, 4'd15, 32'h12345678, 32'h9ABCDEF0, 5'd12, 1'b1);
        bus.fpu_y = 32'h55555555;
      end
      if (k == 1) bus.issue_valid = 1'b0;
      if (k == 8) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_busy",  bus.busy,      1'b0);
        chk("rst_stall", bus.stall_req, 1'b0);
        chk("rst_pend",  bus.pend_rd,   5'd0);
        chk("rst_x1",    bus.fpu_x1,    32'd0);
        chk("rst_cont",  bus.fpu_cont,  5'd0);
        chk("rst_wbd",   bus.wb_data,   32'd0);
      end
      if (k == 9) rst = 1'b0;
      @(negedge clk);
      chk("rst_wbv",   bus.wb_valid, 1'b0);
      chk("rst_busy2", bus.busy, k >= 1 && k <= 7);
      next_cycle();
    end

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      set_issue(1'($urandom_range(0, 1)), 5'($urandom), 4'($urandom), $urandom, $urandom,
                5'($urandom), 1'($urandom_range(0, 1)));
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.fpu_y = $urandom;
      rst = ($urandom_range(0, 255) == 0);
      next_cycle();
    end
    rst = 1'b0;
    set_issue(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    bus.flush = 1'b0;
    repeat (20) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpu_exec_ctrl.md
Name: fpu_exec_ctrl

Overview:
- Execute-stage sequencer that sits between the decode/ALU-decode outputs (fpu_cont, fpu_stall, source/rd register select) and the multi-cycle FPU datapath.
- Captures and holds operands and op code stable for the FPU's full latency, and raises a pipeline stall for exactly that many cycles.
- Samples the FPU result and hands one writeback beat downstream.
- Exports the pending destination register so decode can detect RAW hazards on in-flight FP results.

Parameters:
- DW, 32, operand/result width
- LAT_W, 4, width of fpu_stall latency count (max latency 2^LAT_W-1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- issue_valid  in  1  decode presents an FPU op (alu_cont[4]==1) this cycle
- issue_cont  in  5  fpu_cont code from ALU decode
- issue_lat  in  LAT_W  fpu_stall value from ALU decode
- issue_x1  in  DW  operand 1 (already muxed int/float per source_reg_src)
- issue_x2  in  DW  operand 2
- issue_rd  in  5  destination register index
- issue_rd_f  in  1  rd_reg_src: 1 = float regfile, 0 = integer regfile
- flush  in  1  squash in-flight op (branch/jump redirect)
- fpu_x1  out  DW  held operand 1 to FPU
- fpu_x2  out  DW  held operand 2 to FPU
- fpu_cont  out  5  held op code to FPU
- fpu_y  in  DW  FPU result
- stall_req  out  1  freeze fetch/decode/execute
- busy  out  1  op in flight (WAIT state)
- pend_rd  out  5  destination of in-flight op
- pend_rd_f  out  1  regfile select of in-flight op
- wb_valid  out  1  one-cycle writeback strobe
- wb_data  out  DW  result
- wb_rd  out  5  writeback destination
- wb_rd_f  out  1  writeback regfile select

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0; every output register (fpu_x1, fpu_x2, fpu_cont, pend_rd, pend_rd_f, wb_*) =0; stall_req=0, busy=0.
- States:
  - IDLE: on issue_valid & !flush, latch x1/x2/cont/rd/rd_f and load cnt=issue_lat, then go to WAIT.
  - WAIT: if cnt!=0, cnt--; if cnt==0, sample fpu_y into wb_data, load wb_rd/wb_rd_f, pulse wb_valid next cycle, go to IDLE.
- Timing for an issue in cycle T with latency N:
  - FPU sees held inputs from T+1.
  - Result sampled at the clock edge ending cycle T+1+N.
  - wb_valid=1 during cycle T+2+N only.
- stall_req:
  - Combinational, asserted in cycle T (issue_valid & IDLE & !flush).
  - Registered-asserted through cycle T+1+N inclusive.
  - Deasserted in T+2+N, so decode can issue again in the wb cycle.
- busy=1 exactly while in WAIT.
- pend_rd/pend_rd_f are valid while busy; outside busy they are 0.
- N=0 (fsgnj, feq/flt/fle): one WAIT cycle, wb_valid at T+2, stall_req for T..T+1.
- N=15 (max): counter must not wrap; sample occurs at cnt==0 only.
- issue_valid while busy: ignored; upstream is stalled so this is a protocol violation, and state/latched values must not change.
- Issue in the same cycle as wb_valid: accepted normally; wb beat of the prior op is unaffected.
- flush:
  - In IDLE: blocks capture.
  - In WAIT: state returns to IDLE next edge, no wb_valid, stall_req drops next cycle, pend_rd cleared.
  - flush has priority over a simultaneous counter expiry.
- fpu_x1/fpu_x2/fpu_cont hold their last values in IDLE (not cleared) to avoid FPU input toggling.
- wb_data/wb_rd/wb_rd_f hold their values after the strobe; only wb_valid qualifies them.
- rst asserted mid-WAIT: immediate return to reset values; no wb beat is produced.

Test Plan:
- Reset release, no issue for 10 cycles -> all outputs 0, stall_req never 1.
- fadd at T=0: cont=5'b10000, lat=4, x1=0x3F800000, x2=0x40000000, rd=5, rd_f=1 -> stall_req cycles 0..5, busy 1..5, pend_rd=5 during busy, wb_valid only cycle 6 with wb_data=0x40400000, wb_rd=5, wb_rd_f=1.
- feq (lat=0, cont=5'b10111, x1=x2=0x40490FDB, rd=7, rd_f=0) -> wb_valid at cycle 2, wb_data=0x00000001, wb_rd_f=0, stall_req cycles 0..1.
- fdiv (lat=6) issued, flush at cycle 3 -> no wb_valid ever, busy=0 and stall_req=0 from cycle 4, pend_rd=0; a fresh fadd issued at cycle 5 completes at cycle 11.
- Back-to-back: fmul lat=4 at T=0, second issue_valid held every cycle -> second op accepted at cycle 6 (wb cycle of first), its wb_valid at cycle 12; the issue attempts in cycles 1..5 change nothing.
- lat=15 op, then rst pulsed at cycle 8 -> outputs return to 0 asynchronously within cycle 8, no wb_valid afterwards.
